// File: rtl/util_iic_slave.sv
// util_iic_slave: I2C target with an 8-bit register pointer and one-clk register read/write strobes.
module util_iic_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);
  typedef enum logic [3:0] {IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, IGNORE} state_t;
  logic [1:0]         s1_q, s2_q, f_q, p_q;
  logic [1:0][CW-1:0] cnt_q;
  state_t             state_q;
  logic [3:0]         bit_cnt_q;
  logic [7:0]         shift_q, ptr_q, addr_q, wdata_q;
  logic [6:0]         tx_q;
  logic               rw_q, ld_q, sda_t_q, wr_q, rd_q, busy_q;
  logic               scl_rise, scl_fall, start_c, stop_c, byte_done;
  // Bit 0 carries SCL, bit 1 carries SDA through synchroniser and glitch filter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q  <= 2'b11;
      s2_q  <= 2'b11;
      f_q   <= 2'b11;
      p_q   <= 2'b11;
      cnt_q <= '0;
    end else begin
      s1_q <= {sda_i, scl_i};
      s2_q <= s1_q;
      p_q  <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CMAX) begin
          f_q[i]   <= s2_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  assign scl_rise  = f_q[0] & ~p_q[0];
  assign scl_fall  = ~f_q[0] & p_q[0];
  assign start_c   = f_q[0] & p_q[0] & p_q[1] & ~f_q[1];
  assign stop_c    = f_q[0] & p_q[0] & ~p_q[1] & f_q[1];
  assign byte_done = bit_cnt_q == 4'd8;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      ld_q      <= 1'b0;
      sda_t_q   <= 1'b1;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      ld_q <= rd_q;
      if (scl_rise) begin
        shift_q   <= {shift_q[6:0], f_q[1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (start_c) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_t_q   <= 1'b1;
        busy_q    <= 1'b1;
        ld_q      <= 1'b0;
      end else if (stop_c) begin
        state_q <= IDLE;
        sda_t_q <= 1'b1;
        busy_q  <= 1'b0;
        ld_q    <= 1'b0;
      end else if (ld_q && state_q == RDATA) begin
        // Read data arrives one clk after the strobe; bit 7 goes out immediately.
        tx_q    <= reg_rdata[6:0];
        sda_t_q <= reg_rdata[7];
      end else if (scl_fall) begin
        case (state_q)
          ADDR: if (byte_done) begin
            bit_cnt_q <= '0;
            rw_q      <= shift_q[0];
            if (shift_q[7:1] == SLAVE_ADDR) begin
              sda_t_q <= 1'b0;
              state_q <= ADDR_ACK;
            end else begin
              state_q <= IGNORE;
              busy_q  <= 1'b0;
            end
          end
          ADDR_ACK: begin
            sda_t_q   <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= rw_q ? RDATA : PTR;
            rd_q      <= rw_q;
            if (rw_q) addr_q <= ptr_q;
          end
          PTR: if (byte_done) begin
            ptr_q     <= shift_q;
            sda_t_q   <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= PTR_ACK;
          end
          PTR_ACK: begin
            sda_t_q   <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= WDATA;
          end
          WDATA: if (byte_done) begin
            wr_q      <= 1'b1;
            addr_q    <= ptr_q;
            wdata_q   <= shift_q;
            sda_t_q   <= 1'b0;
            bit_cnt_q <= '0;
            state_q   <= WACK;
          end
          WACK: begin
            sda_t_q   <= 1'b1;
            ptr_q     <= ptr_q + 8'd1;
            bit_cnt_q <= '0;
            state_q   <= WDATA;
          end
          RDATA: if (byte_done) begin
            sda_t_q   <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= RACK;
          end else begin
            sda_t_q <= tx_q[6];
            tx_q    <= {tx_q[5:0], 1'b1};
          end
          // shift_q[0] holds the master's ACK bit sampled on the preceding rise.
          RACK: if (shift_q[0]) state_q <= IGNORE;
          else begin
            ptr_q     <= ptr_q + 8'd1;
            addr_q    <= ptr_q + 8'd1;
            rd_q      <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= RDATA;
          end
          default: ;
        endcase
      end
    end
  end
  assign sda_o     = 1'b0;
  assign sda_t     = sda_t_q;
  assign reg_wr_en = wr_q;
  assign reg_rd_en = rd_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_util_iic_slave.sv
// tb_util_iic_slave: directed I2C master driving util_iic_slave, register strobes checked against a scoreboard.
module tb_util_iic_slave;
  localparam int Q = 100;
  logic       clk = 1'b0, rstn = 1'b0, scl = 1'b1, m_sda = 1'b1;
  logic       sda_o, sda_t, reg_wr_en, reg_rd_en, busy, sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  int         n_chk = 0, n_fail = 0, n_wr = 0, n_rd = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] we;
  logic [7:0]  re;
  util_iic_slave #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk(clk), .rstn(rstn), .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy)
  );
  assign sda_bus   = m_sda & (sda_t | sda_o);
  assign reg_rdata = reg_addr ^ 8'h33;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reg_wr_en) begin
      n_wr++;
      we = (wr_q.size() != 0) ? wr_q.pop_front() : 16'hxxxx;
      chk("reg_write", {reg_addr, reg_wdata}, {16'h0, we});
    end
    if (reg_rd_en) begin
      n_rd++;
      re = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hxx;
      chk("reg_read_addr", reg_addr, {24'h0, re});
    end
  end
  task automatic bit_w(input logic b, input logic g);
    #Q m_sda = b;
    #Q scl = 1'b1;
    if (g) begin
      #50 scl = 1'b0;
      #10 scl = 1'b1;
      #50 scl = 1'b0;
      #10 scl = 1'b1;
      #80;
    end else #(2*Q);
    scl = 1'b0;
  endtask
  task automatic start_c;
    #Q m_sda = 1'b1;
    #Q scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q scl = 1'b0;
  endtask
  task automatic stop_c;
    #Q m_sda = 1'b0;
    #Q scl = 1'b1;
    #Q m_sda = 1'b1;
    #Q;
  endtask
  task automatic wr_byte(input logic [7:0] b, input logic g, output logic ack);
    for (int i = 7; i >= 0; i--) bit_w(b[i], g);
    #Q m_sda = 1'b1;
    #Q scl = 1'b1;
    #Q ack = sda_bus;
    #Q scl = 1'b0;
  endtask
  task automatic rd_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      #Q m_sda = 1'b1;
      #Q scl = 1'b1;
      #Q d[i] = sda_bus;
      #Q scl = 1'b0;
    end
    #Q m_sda = mack;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask
  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic       ack;
    logic [7:0] d, b;
    int         w0, r0;
    #100;
    chk("rst_sda_t", sda_t, 1);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    rstn = 1'b1;
    #200;
    // Write transaction with two data bytes
    wr_q.push_back(16'h105A);
    wr_q.push_back(16'h116B);
    start_c;
    chk("w_busy_start", busy, 1);
    wr_byte(8'hA0, 1'b0, ack); chk("w_ack_addr", ack, 0);
    wr_byte(8'h10, 1'b0, ack); chk("w_ack_ptr", ack, 0);
    wr_byte(8'h5A, 1'b0, ack); chk("w_ack_d0", ack, 0);
    wr_byte(8'h6B, 1'b0, ack); chk("w_ack_d1", ack, 0);
    stop_c;
    chk("w_busy_stop", busy, 0);
    chk("w_sda_t_stop", sda_t, 1);
    chk("w_wr_count", n_wr, 2);
    // Pointer set, repeated START, read with wrap
    rd_q.push_back(8'hFF);
    rd_q.push_back(8'h00);
    start_c;
    wr_byte(8'hA0, 1'b0, ack); chk("r_ack_addr", ack, 0);
    wr_byte(8'hFF, 1'b0, ack); chk("r_ack_ptr", ack, 0);
    start_c;
    chk("r_busy_sr", busy, 1);
    wr_byte(8'hA1, 1'b0, ack); chk("r_ack_addr_rd", ack, 0);
    rd_byte(1'b0, d); chk("r_byte0", d, 8'hCC);
    rd_byte(1'b1, d); chk("r_byte1", d, 8'h33);
    chk("r_sda_released", sda_t, 1);
    stop_c;
    chk("r_rd_count", n_rd, 2);
    chk("r_rd_pending", rd_q.size(), 0);
    chk("r_busy_stop", busy, 0);
    chk("r_no_write", n_wr, 2);
    // Address mismatch
    w0 = n_wr;
    r0 = n_rd;
    start_c;
    wr_byte(8'hA2, 1'b0, ack); chk("m_nack_addr", ack, 1);
    chk("m_busy_ignore", busy, 0);
    wr_byte(8'h55, 1'b0, ack); chk("m_nack_data", ack, 1);
    chk("m_busy_still", busy, 0);
    chk("m_no_wr", n_wr, w0);
    chk("m_no_rd", n_rd, r0);
    start_c;
    chk("m_busy_restart", busy, 1);
    stop_c;
    chk("m_busy_stop", busy, 0);
    // STOP in the middle of a data byte
    start_c;
    wr_byte(8'hA0, 1'b0, ack); chk("p_ack_addr", ack, 0);
    wr_byte(8'h40, 1'b0, ack); chk("p_ack_ptr", ack, 0);
    for (int i = 0; i < 4; i++) bit_w(1'b1, 1'b0);
    stop_c;
    chk("p_no_wr", n_wr, w0);
    chk("p_busy", busy, 0);
    chk("p_sda_t", sda_t, 1);
    // SCL glitches during the high phase of every data bit
    wr_q.push_back(16'h2096);
    start_c;
    wr_byte(8'hA0, 1'b0, ack); chk("g_ack_addr", ack, 0);
    wr_byte(8'h20, 1'b0, ack); chk("g_ack_ptr", ack, 0);
    wr_byte(8'h96, 1'b1, ack); chk("g_ack_data", ack, 0);
    stop_c;
    chk("g_wr_count", n_wr, w0 + 1);
    chk("g_wr_pending", wr_q.size(), 0);
    // Asynchronous reset while the slave holds SDA low for ACK
    start_c;
    b = 8'hA0;
    for (int i = 7; i >= 0; i--) bit_w(b[i], 1'b0);
    #Q m_sda = 1'b1;
    #Q scl = 1'b1;
    #Q chk("x_ack_driven", sda_t, 0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("x_async_sda_t", sda_t, 1);
    chk("x_async_busy", busy, 0);
    #2 scl = 1'b1;
    m_sda = 1'b1;
    #100 rstn = 1'b1;
    #200;
    // Recovery after reset, with pointer wrap on writes
    wr_q.push_back(16'hFF01);
    wr_q.push_back(16'h0002);
    start_c;
    wr_byte(8'hA0, 1'b0, ack); chk("y_ack_addr", ack, 0);
    wr_byte(8'hFF, 1'b0, ack); chk("y_ack_ptr", ack, 0);
    wr_byte(8'h01, 1'b0, ack); chk("y_ack_d0", ack, 0);
    wr_byte(8'h02, 1'b0, ack); chk("y_ack_d1", ack, 0);
    stop_c;
    chk("y_wr_count", n_wr, w0 + 3);
    chk("y_wr_pending", wr_q.size(), 0);
    chk("y_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
